// File: rtl/mmio_io_hub_pkg.sv
// Shared constants for the memory-mapped board I/O hub: register offsets and bus data width.
package mmio_io_hub_pkg;

  localparam int unsigned IO_NREGS  = 8;
  localparam int unsigned IO_DATA_W = 32;

  // Word offsets from BASE_ADDR.
  localparam logic [2:0] IO_IN       = 3'd0;
  localparam logic [2:0] IO_RISE     = 3'd1;
  localparam logic [2:0] IO_FALL     = 3'd2;
  localparam logic [2:0] IO_OUT      = 3'd3;
  localparam logic [2:0] IO_OUT_SET  = 3'd4;
  localparam logic [2:0] IO_OUT_CLR  = 3'd5;
  localparam logic [2:0] IO_CYCLE    = 3'd6;
  localparam logic [2:0] IO_IRQ_MASK = 3'd7;

endpackage

// File: rtl/mmio_io_hub_if.sv
// Processor dmem-side bus between the CPU (master) and the I/O hub (slave).
interface mmio_io_hub_if #(
  parameter int unsigned ADDR_W = 12
) ();

  logic [ADDR_W-1:0] address_dmem;
  logic              wren;
  logic [31:0]       data;
  logic              sel;
  logic              hit_q;
  logic [31:0]       q_io;

  modport master (
    output address_dmem,
    output wren,
    output data,
    input  sel,
    input  hit_q,
    input  q_io
  );

  modport slave (
    input  address_dmem,
    input  wren,
    input  data,
    output sel,
    output hit_q,
    output q_io
  );

endinterface

// File: rtl/mmio_io_hub_debounce.sv
// One input channel: two-flop synchroniser followed by a level debouncer. A new level is only
// accepted after it has differed from the accepted level for DB_CYCLES consecutive cycles.
// rise/fall pulse for one cycle, aligned with the edge that updates the accepted level.
module mmio_io_hub_debounce #(
  parameter int unsigned DB_CYCLES = 1000000
) (
  input  logic clock,
  input  logic reset,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int unsigned     CntW    = $clog2(DB_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(DB_CYCLES - 1);

  logic            sync1_q;
  logic            sync2_q;
  logic            stable_q;
  logic            stable_d;
  logic [CntW-1:0] cnt_q;
  logic [CntW-1:0] cnt_d;
  logic            update;

  // Debounce next-state: count mismatching cycles, accept the new level on the last one.
  always_comb begin
    cnt_d    = '0;
    stable_d = stable_q;
    update   = 1'b0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CntLast) begin
        stable_d = sync2_q;
        update   = 1'b1;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  // Synchroniser, counter and accepted level.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= pin;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign level = stable_q;
  assign rise  = update & sync2_q;
  assign fall  = update & ~sync2_q;

endmodule

// File: rtl/mmio_io_hub.sv
// Memory-mapped board I/O hub on the dmem bus: debounced inputs, sticky W1C edge flags, LED
// output register with set/clear aliases, free-running cycle counter and a maskable rise IRQ.
// Reads return one cycle after the address, like the neighbouring RAM.
module mmio_io_hub
  import mmio_io_hub_pkg::*;
#(
  parameter int unsigned N_IN      = 16,
  parameter int unsigned N_OUT     = 16,
  parameter int unsigned DB_CYCLES = 1000000,
  parameter int unsigned ADDR_W    = 12,
  parameter int unsigned BASE_ADDR = 'hF00  // must be 8-word aligned
) (
  input  logic              clock,
  input  logic              reset,
  mmio_io_hub_if.slave      bus,
  input  logic [N_IN-1:0]   pins_in,
  output logic [N_OUT-1:0]  pins_out,
  output logic              irq
);

  localparam logic [ADDR_W-1:0] BaseAddr = ADDR_W'(BASE_ADDR);

  logic [2:0]           offset;
  logic                 sel;
  logic                 wr_hit;

  logic [N_IN-1:0]      stable;
  logic [N_IN-1:0]      rise_set;
  logic [N_IN-1:0]      fall_set;
  logic [N_IN-1:0]      rise_clr;
  logic [N_IN-1:0]      fall_clr;

  logic [N_IN-1:0]      rise_q;
  logic [N_IN-1:0]      rise_d;
  logic [N_IN-1:0]      fall_q;
  logic [N_IN-1:0]      fall_d;
  logic [N_OUT-1:0]     out_q;
  logic [N_OUT-1:0]     out_d;
  logic [N_IN-1:0]      mask_q;
  logic [N_IN-1:0]      mask_d;
  logic [IO_DATA_W-1:0] cycle_q;
  logic [IO_DATA_W-1:0] rdata;
  logic [IO_DATA_W-1:0] q_io_q;
  logic                 hit_reg_q;
  logic                 irq_q;

  // Only the low N_IN/N_OUT data bits are stored; the rest are intentionally ignored.
  logic unused_data;
  assign unused_data = ^bus.data;

  // Block decode: the 8 registers occupy one aligned group of 8 words.
  assign offset  = bus.address_dmem[2:0];
  assign sel     = (bus.address_dmem[ADDR_W-1:3] == BaseAddr[ADDR_W-1:3]);
  assign wr_hit  = bus.wren & sel;
  assign bus.sel = sel;

  // Per-channel synchroniser and debouncer.
  for (genvar i = 0; i < int'(N_IN); i++) begin : gen_in
    mmio_io_hub_debounce #(
      .DB_CYCLES(DB_CYCLES)
    ) u_debounce (
      .clock(clock),
      .reset(reset),
      .pin  (pins_in[i]),
      .level(stable[i]),
      .rise (rise_set[i]),
      .fall (fall_set[i])
    );
  end

  // Register write decode; a fresh edge in the same cycle as a W1C keeps its flag set.
  always_comb begin
    rise_clr = '0;
    fall_clr = '0;
    out_d    = out_q;
    mask_d   = mask_q;
    if (wr_hit) begin
      case (offset)
        IO_RISE:     rise_clr = bus.data[N_IN-1:0];
        IO_FALL:     fall_clr = bus.data[N_IN-1:0];
        IO_OUT:      out_d    = bus.data[N_OUT-1:0];
        IO_OUT_SET:  out_d    = out_q | bus.data[N_OUT-1:0];
        IO_OUT_CLR:  out_d    = out_q & ~bus.data[N_OUT-1:0];
        IO_IRQ_MASK: mask_d   = bus.data[N_IN-1:0];
        default:     ;
      endcase
    end
    rise_d = (rise_q & ~rise_clr) | rise_set;
    fall_d = (fall_q & ~fall_clr) | fall_set;
  end

  // Read mux; side-effect free, zero outside the block.
  always_comb begin
    rdata = '0;
    if (sel) begin
      case (offset)
        IO_IN:       rdata = IO_DATA_W'(stable);
        IO_RISE:     rdata = IO_DATA_W'(rise_q);
        IO_FALL:     rdata = IO_DATA_W'(fall_q);
        IO_OUT:      rdata = IO_DATA_W'(out_q);
        IO_OUT_SET:  rdata = IO_DATA_W'(out_q);
        IO_OUT_CLR:  rdata = IO_DATA_W'(out_q);
        IO_CYCLE:    rdata = cycle_q;
        IO_IRQ_MASK: rdata = IO_DATA_W'(mask_q);
        default:     rdata = '0;
      endcase
    end
  end

  // Register bank, cycle counter, registered read port and IRQ.
  always_ff @(posedge clock) begin
    if (reset) begin
      rise_q    <= '0;
      fall_q    <= '0;
      out_q     <= '0;
      mask_q    <= '0;
      cycle_q   <= '0;
      q_io_q    <= '0;
      hit_reg_q <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      out_q     <= out_d;
      mask_q    <= mask_d;
      cycle_q   <= cycle_q + IO_DATA_W'(1);
      q_io_q    <= rdata;
      hit_reg_q <= sel;
      irq_q     <= |(rise_q & mask_q);
    end
  end

  assign bus.q_io  = q_io_q;
  assign bus.hit_q = hit_reg_q;
  assign pins_out  = out_q;
  assign irq       = irq_q;

endmodule

// File: tb/tb_mmio_io_hub.sv
// Directed bench for mmio_io_hub with DB_CYCLES = 4. Read expectations are queued when the read
// is driven and compared when the registered read data appears one edge later.
module tb_mmio_io_hub;

  localparam int unsigned     NIn  = 16;
  localparam int unsigned     NOut = 16;
  localparam logic [11:0]     Base = 12'hF00;

  localparam logic [2:0] OffIn   = 3'd0;
  localparam logic [2:0] OffRise = 3'd1;
  localparam logic [2:0] OffFall = 3'd2;
  localparam logic [2:0] OffOut  = 3'd3;
  localparam logic [2:0] OffSet  = 3'd4;
  localparam logic [2:0] OffClr  = 3'd5;
  localparam logic [2:0] OffCyc  = 3'd6;
  localparam logic [2:0] OffMask = 3'd7;

  typedef struct packed {
    logic        chk;
    logic        hit;
    logic [31:0] q;
  } exp_t;

  logic            clock;
  logic            reset;
  logic [NIn-1:0]  pins_in;
  logic [NOut-1:0] pins_out;
  logic            irq;

  exp_t        sb[$];
  string       tag_q[$];
  int unsigned checks;
  int unsigned errors;
  logic [31:0] cyc;

  mmio_io_hub_if #(.ADDR_W(12)) bus ();

  mmio_io_hub #(
    .N_IN     (NIn),
    .N_OUT    (NOut),
    .DB_CYCLES(4),
    .ADDR_W   (12),
    .BASE_ADDR('hF00)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .bus     (bus),
    .pins_in (pins_in),
    .pins_out(pins_out),
    .irq     (irq)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Drive one bus cycle and queue what the read port must show after the next edge.
  task automatic drive(input logic [11:0] a, input logic w, input logic [31:0] d,
                       input logic chk, input logic [31:0] q, input string tag);
    exp_t e;
    bus.address_dmem = a;
    bus.wren         = w;
    bus.data         = d;
    e.chk = chk;
    e.hit = (a[11:3] == Base[11:3]) && !reset;
    e.q   = q;
    sb.push_back(e);
    tag_q.push_back(tag);
  endtask

  // Advance one clock, update the cycle-counter model, compare any queued read, go idle.
  task automatic step();
    exp_t  e;
    string t;
    @(posedge clock);
    cyc = reset ? 32'd0 : cyc + 32'd1;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      t = tag_q.pop_front();
      if (e.chk) begin
        check({t, "_hit"}, 32'(bus.hit_q), 32'(e.hit));
        check({t, "_q"}, bus.q_io, e.q);
      end
    end
    bus.address_dmem = 12'h100;
    bus.wren         = 1'b0;
    bus.data         = '0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic rd(input logic [2:0] off, input logic [31:0] q, input string tag);
    drive(Base + 12'(off), 1'b0, 32'd0, 1'b1, q, tag);
    step();
  endtask

  task automatic wr(input logic [2:0] off, input logic [31:0] d);
    drive(Base + 12'(off), 1'b1, d, 1'b0, 32'd0, "wr");
    step();
  endtask

  task automatic sel_chk(input logic [11:0] a, input logic expv, input string tag);
    bus.address_dmem = a;
    bus.wren         = 1'b0;
    #1;
    check(tag, 32'(bus.sel), 32'(expv));
  endtask

  initial begin
    checks           = 0;
    errors           = 0;
    cyc              = 32'd0;
    reset            = 1'b1;
    pins_in          = '0;
    bus.address_dmem = 12'h100;
    bus.wren         = 1'b0;
    bus.data         = '0;

    // Reset state.
    idle(3);
    check("rst_pins_out", 32'(pins_out), 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_hit", 32'(bus.hit_q), 32'd0);
    check("rst_q", bus.q_io, 32'd0);
    reset = 1'b0;
    rd(OffCyc, cyc, "cycle0");
    rd(OffCyc, cyc, "cycle1");
    rd(OffIn, 32'd0, "in_rst");
    rd(OffRise, 32'd0, "rise_rst");
    rd(OffOut, 32'd0, "out_rst");

    // Pin 0 rises: IN updates 2+DB_CYCLES edges later, seen on the read one edge after that.
    pins_in[0] = 1'b1;
    for (int k = 1; k <= 7; k++) rd(OffIn, (k < 7) ? 32'd0 : 32'd1, "in_latency");
    rd(OffRise, 32'd1, "rise_pin0");
    rd(OffFall, 32'd0, "fall_pin0");
    check("irq_masked", 32'(irq), 32'd0);

    // A 3-cycle glitch on pin 1 is filtered out.
    pins_in[1] = 1'b1;
    idle(3);
    pins_in[1] = 1'b0;
    idle(8);
    rd(OffIn, 32'd1, "glitch_in");
    rd(OffRise, 32'd1, "glitch_rise");
    rd(OffFall, 32'd0, "glitch_fall");

    // W1C: zeros leave flags alone, ones clear them.
    wr(OffRise, 32'd0);
    rd(OffRise, 32'd1, "w1c_zero");
    wr(OffRise, 32'd1);
    rd(OffRise, 32'd0, "w1c_one");

    // Pin 0 falls.
    pins_in[0] = 1'b0;
    idle(8);
    rd(OffIn, 32'd0, "in_fall");
    rd(OffFall, 32'd1, "fall_set");
    wr(OffFall, 32'd1);
    rd(OffFall, 32'd0, "fall_clr");

    // IRQ: unmask bit 0, raise pin 0, then clear the flag.
    wr(OffMask, 32'd1);
    rd(OffMask, 32'd1, "mask_rd");
    pins_in[0] = 1'b1;
    idle(6);
    check("irq_before", 32'(irq), 32'd0);
    step();
    check("irq_set", 32'(irq), 32'd1);
    wr(OffRise, 32'd1);
    check("irq_hold", 32'(irq), 32'd1);
    rd(OffRise, 32'd0, "rise_after_w1c");
    check("irq_clr", 32'(irq), 32'd0);

    // New rise on the same edge as a W1C of that bit: the set wins.
    pins_in[0] = 1'b0;
    idle(8);
    pins_in[0] = 1'b1;
    idle(5);
    wr(OffRise, 32'd1);
    rd(OffRise, 32'd1, "set_wins");
    wr(OffRise, 32'd1);
    wr(OffMask, 32'd0);

    // OUT register and its set/clear aliases.
    wr(OffOut, 32'h00F0);
    check("out_write", 32'(pins_out), 32'h00F0);
    wr(OffSet, 32'h000F);
    check("out_set", 32'(pins_out), 32'h00FF);
    wr(OffClr, 32'h0080);
    check("out_clr", 32'(pins_out), 32'h007F);
    rd(OffOut, 32'h7F, "rd_out");
    rd(OffSet, 32'h7F, "rd_out_set");
    rd(OffClr, 32'h7F, "rd_out_clr");
    drive(12'hF0B, 1'b1, 32'hFFFF, 1'b0, 32'd0, "wr_miss");
    step();
    check("out_miss", 32'(pins_out), 32'h007F);
    rd(OffCyc, cyc, "cycle_run");

    // Address decode boundaries.
    sel_chk(12'hF07, 1'b1, "sel_top");
    sel_chk(12'hF08, 1'b0, "sel_above");
    sel_chk(12'hEFF, 1'b0, "sel_below");
    sel_chk(12'hF00, 1'b1, "sel_base");

    // Reset mid-debounce on pin 2 with all LEDs on.
    wr(OffOut, 32'hFFFF);
    check("out_ffff", 32'(pins_out), 32'hFFFF);
    pins_in[2] = 1'b1;
    idle(4);
    reset = 1'b1;
    drive(12'h100, 1'b0, 32'd0, 1'b1, 32'd0, "rst_rd");
    #1;
    check("rst_sel", 32'(bus.sel), 32'd0);
    step();
    check("rst_mid_pins_out", 32'(pins_out), 32'd0);
    check("rst_mid_irq", 32'(irq), 32'd0);
    reset = 1'b0;

    // Pins held high through reset debounce again from zero and report a rise.
    for (int k = 1; k <= 7; k++) rd(OffIn, (k < 7) ? 32'd0 : 32'd5, "in_after_rst");
    rd(OffRise, 32'd5, "rise_after_rst");
    rd(OffMask, 32'd0, "mask_after_rst");
    check("irq_after_rst", 32'(irq), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
